// File: rtl/score_pkg.sv
// Shared types and BCD helpers for the score controller.
package score_pkg;

  localparam int MAX_SCORE_DEF = 99;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ADD  = 1'b1
  } score_state_t;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  // Add one to a two-digit BCD value; units roll 9 -> 0 and carry into tens.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    if (v.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
      r.tens  = v.tens;
    end
    return r;
  endfunction

  // tens*10 + units using shifts only (x*10 = x*8 + x*2).
  function automatic logic [9:0] bcd_to_bin(input bcd2_t v);
    logic [9:0] t;
    t = {6'd0, v.tens};
    return (t << 3) + (t << 1) + {6'd0, v.units};
  endfunction

endpackage

// File: rtl/score_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int   idx;
  logic hit;

  // Walk the requests starting from ptr, wrapping, and take the first one set.
  always_comb begin
    gnt     = {N_REQ{1'b0}};
    gnt_idx = {IDX_W{1'b0}};
    any     = 1'b0;
    idx     = 0;
    hit     = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx          = (int'(ptr) + k) % N_REQ;
      hit          = en && !any && req[idx];
      gnt[idx]     = gnt[idx] | hit;
      gnt_idx      = hit ? IDX_W'(idx) : gnt_idx;
      any          = any | hit;
    end
  end

endmodule

// File: rtl/score_ctrl.sv
// Score controller: arbitrates kill events, accumulates BCD score with
// saturation, and publishes tear-free display values on frame_sync.
module score_ctrl
  import score_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PTS_W     = 4,
  parameter int MAX_SCORE = MAX_SCORE_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   frame_sync,
  input  logic [N_REQ-1:0]       kill_req,
  input  logic [N_REQ*PTS_W-1:0] kill_pts,
  output logic [N_REQ-1:0]       kill_ack,
  output logic                   busy,
  output logic [9:0]             Total_Score,
  output logic [3:0]             Ten_Digit,
  output logic [3:0]             Unit_Digit,
  output logic                   score_max
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  score_state_t     state;
  logic [PTR_W-1:0] ptr;
  logic [PTS_W-1:0] rem;
  bcd2_t            work;

  logic [N_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;
  logic             any;
  logic             arb_en;
  logic [PTS_W-1:0] pts_sel;
  bcd2_t            work_inc;
  logic [9:0]       work_bin;
  logic             at_max;

  // Grants only from idle, never in a clear cycle, never while held in reset.
  assign arb_en   = (state == S_IDLE) && !clear && !Reset;
  assign kill_ack = gnt;
  assign busy     = (state == S_ADD);
  assign pts_sel  = kill_pts[int'(gnt_idx)*PTS_W +: PTS_W];
  assign work_inc = bcd_inc(work);
  assign work_bin = bcd_to_bin(work);
  assign at_max   = (work_bin == 10'(MAX_SCORE));

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (PTR_W)
  ) u_arb (
    .req     (kill_req),
    .ptr     (ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Control FSM, working score, round-robin pointer and display shadow.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= S_IDLE;
      ptr         <= {PTR_W{1'b0}};
      rem         <= {PTS_W{1'b0}};
      work        <= '{default: 4'd0};
      score_max   <= 1'b0;
      Total_Score <= 10'd0;
      Ten_Digit   <= 4'd0;
      Unit_Digit  <= 4'd0;
    end else if (clear) begin
      // New game: drop any add in progress; pointer keeps its position.
      state       <= S_IDLE;
      rem         <= {PTS_W{1'b0}};
      work        <= '{default: 4'd0};
      score_max   <= 1'b0;
      Total_Score <= 10'd0;
      Ten_Digit   <= 4'd0;
      Unit_Digit  <= 4'd0;
    end else begin
      // Shadow takes the pre-edge working value, so a coincident increment is not shown yet.
      if (frame_sync) begin
        Total_Score <= work_bin;
        Ten_Digit   <= work.tens;
        Unit_Digit  <= work.units;
      end
      case (state)
        S_IDLE: begin
          if (any) begin
            ptr   <= (gnt_idx == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : gnt_idx + 1'b1;
            rem   <= pts_sel;
            state <= (pts_sel != {PTS_W{1'b0}}) ? S_ADD : S_IDLE;
          end
        end
        S_ADD: begin
          if (at_max) begin
            // Saturated: discard what is left of this event.
            rem       <= {PTS_W{1'b0}};
            score_max <= 1'b1;
            state     <= S_IDLE;
          end else begin
            work <= work_inc;
            rem  <= rem - PTS_W'(1);
            if (bcd_to_bin(work_inc) == 10'(MAX_SCORE)) begin
              score_max <= 1'b1;
            end
            if (rem <= PTS_W'(1)) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_ctrl.sv
// Self-checking bench for score_ctrl: directed scenarios plus random traffic
// compared each cycle against an integer-level reference model.
module tb_score_ctrl;

  localparam int N    = 4;
  localparam int PW   = 4;
  localparam int MAXS = 99;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          clear;
  logic          frame_sync;
  logic [N-1:0]  kill_req;
  logic [N*PW-1:0] kill_pts;
  logic [N-1:0]  kill_ack;
  logic          busy;
  logic [9:0]    Total_Score;
  logic [3:0]    Ten_Digit;
  logic [3:0]    Unit_Digit;
  logic          score_max;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integers for score, pending points, pointer, shadow.
  int m_score, m_pend, m_ptr, m_shadow;
  bit m_busy, m_max;

  score_ctrl #(.N_REQ(N), .PTS_W(PW), .MAX_SCORE(MAXS)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear       (clear),
    .frame_sync  (frame_sync),
    .kill_req    (kill_req),
    .kill_pts    (kill_pts),
    .kill_ack    (kill_ack),
    .busy        (busy),
    .Total_Score (Total_Score),
    .Ten_Digit   (Ten_Digit),
    .Unit_Digit  (Unit_Digit),
    .score_max   (score_max)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_score = 0; m_pend = 0; m_ptr = 0; m_shadow = 0;
    m_busy = 1'b0; m_max = 1'b0;
  endfunction

  // Which requester should be acknowledged this cycle, or -1.
  function automatic int model_grant();
    int i;
    if (m_busy || clear || Reset || kill_req == '0) return -1;
    for (int k = 0; k < N; k++) begin
      i = (m_ptr + k) % N;
      if (kill_req[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_edge(input int g);
    int p;
    if (clear) begin
      m_score = 0; m_pend = 0; m_busy = 1'b0; m_max = 1'b0; m_shadow = 0;
    end else begin
      if (frame_sync) m_shadow = m_score;
      if (!m_busy) begin
        if (g >= 0) begin
          p = int'(kill_pts[g*PW +: PW]);
          m_ptr = (g + 1) % N;
          if (p != 0) begin m_pend = p; m_busy = 1'b1; end
        end
      end else if (m_score < MAXS) begin
        m_score++;
        m_pend--;
        if (m_pend == 0) m_busy = 1'b0;
      end else begin
        m_pend = 0;
        m_busy = 1'b0;
      end
      if (m_score == MAXS) m_max = 1'b1;
    end
  endfunction

  task automatic check_outputs();
    int g;
    logic [N-1:0] ea;
    g  = model_grant();
    ea = '0;
    if (g >= 0) ea[g] = 1'b1;
    check("ack",   32'(kill_ack),    32'(ea));
    check("busy",  32'(busy),        32'(m_busy));
    check("total", 32'(Total_Score), m_shadow);
    check("ten",   32'(Ten_Digit),   m_shadow / 10);
    check("unit",  32'(Unit_Digit),  m_shadow % 10);
    check("max",   32'(score_max),   32'(m_max));
  endtask

  // One clock: check mid-cycle, advance model at the edge, then requester drops acked req.
  task automatic cycle();
    int g;
    @(negedge Clk);
    check_outputs();
    g = model_grant();
    @(posedge Clk);
    model_edge(g);
    #1;
    if (g >= 0) kill_req[g] = 1'b0;
    frame_sync = 1'b0;
    clear      = 1'b0;
  endtask

  task automatic raise(input int i, input int p);
    kill_req[i] = 1'b1;
    kill_pts[i*PW +: PW] = PW'(p);
  endtask

  task automatic do_reset();
    Reset = 1'b1; clear = 1'b0; frame_sync = 1'b0;
    kill_req = '0; kill_pts = '0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  initial begin
    do_reset();
    cycle(); cycle();

    // 1: single 3-point kill, then display it
    raise(1, 3);
    #1 check("t1_ack", 32'(kill_ack), 32'd2);
    repeat (5) cycle();
    frame_sync = 1'b1;
    cycle();
    #1;
    check("t1_total", 32'(Total_Score), 32'd3);
    check("t1_ten",   32'(Ten_Digit),   32'd0);
    check("t1_unit",  32'(Unit_Digit),  32'd3);

    // 2: two simultaneous requests from pointer 0
    do_reset();
    raise(0, 1); raise(2, 1);
    #1 check("t2_first", 32'(kill_ack), 32'd1);
    cycle(); cycle();
    #1 check("t2_second", 32'(kill_ack), 32'd4);
    cycle(); cycle();
    raise(0, 1); raise(3, 1);
    #1 check("t2_ptr3", 32'(kill_ack), 32'd8);
    repeat (6) cycle();

    // 3: 08 + 5 carries into tens
    clear = 1'b1; cycle();
    raise(1, 8); repeat (11) cycle();
    raise(2, 5); repeat (7) cycle();
    frame_sync = 1'b1; cycle();
    #1;
    check("t3_total", 32'(Total_Score), 32'd13);
    check("t3_ten",   32'(Ten_Digit),   32'd1);
    check("t3_unit",  32'(Unit_Digit),  32'd3);

    // 4: saturation at 99
    clear = 1'b1; cycle();
    for (int k = 0; k < 6; k++) begin raise(k % N, 15); repeat (17) cycle(); end
    raise(0, 7); repeat (9) cycle();
    frame_sync = 1'b1; cycle();
    #1 check("t4_97", 32'(Total_Score), 32'd97);
    raise(1, 5);
    repeat (3) cycle();
    #1 check("t4_busy_sat", 32'(busy), 32'd1);
    cycle();
    #1 check("t4_busy_early", 32'(busy), 32'd0);
    frame_sync = 1'b1; cycle();
    #1;
    check("t4_99",  32'(Total_Score), 32'd99);
    check("t4_max", 32'(score_max),   32'd1);
    raise(2, 4); repeat (6) cycle();
    frame_sync = 1'b1; cycle();
    #1 check("t4_hold", 32'(Total_Score), 32'd99);

    // 5: clear mid-add together with frame_sync
    clear = 1'b1; cycle();
    raise(3, 6); cycle(); cycle(); cycle();
    clear = 1'b1; frame_sync = 1'b1; cycle();
    #1;
    check("t5_busy",  32'(busy),        32'd0);
    check("t5_total", 32'(Total_Score), 32'd0);
    repeat (3) cycle();

    // 6: zero-point kill, then async reset mid-add
    raise(0, 0);
    #1 check("t6_ack", 32'(kill_ack), 32'd1);
    cycle();
    #1 check("t6_busy", 32'(busy), 32'd0);
    repeat (2) cycle();
    raise(1, 9); repeat (4) cycle();
    frame_sync = 1'b1; cycle();
    #1 check("t6_pre", 32'(Total_Score), 32'd3);
    #2 Reset = 1'b1;
    #1;
    check("t6_rst_total", 32'(Total_Score), 32'd0);
    check("t6_rst_busy",  32'(busy),        32'd0);
    check("t6_rst_ack",   32'(kill_ack),    32'd0);
    check("t6_rst_unit",  32'(Unit_Digit),  32'd0);
    model_reset();
    kill_req = '0;
    @(posedge Clk);
    #1 Reset = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      cycle();
      for (int i = 0; i < N; i++) begin
        if (!kill_req[i] && $urandom_range(0, 3) == 0) raise(i, int'($urandom_range(0, 15)));
      end
      frame_sync = ($urandom_range(0, 7) == 0);
      clear      = ($urandom_range(0, 99) == 0);
    end
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
